// File: rtl/l2_cache_ctrl_param_pkg.sv
// Shared types and tree-PLRU helpers for the parametrised L2 cache controller.
// Trees are heap ordered (node 0 = root); a 0 bit means the victim is in the left subtree.
package l2_cache_ctrl_param_pkg;

    localparam int unsigned MAX_WAYS = 16;
    localparam int unsigned MAX_TW   = MAX_WAYS - 1;
    localparam int unsigned MAX_LW   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2,
        HOLD = 2'd3
    } l2_state_e;

    function automatic int unsigned plru_width(input int unsigned ways);
        return ways - 1;
    endfunction

    // Follow the tree bits from the root down to a leaf.
    function automatic logic [MAX_LW-1:0] plru_victim(input logic [MAX_TW-1:0] tree,
                                                      input int unsigned       ways);
        logic [4:0]  node;
        int unsigned lw;
        node = '0;
        lw   = $clog2(ways);
        for (int unsigned lvl = 0; lvl < MAX_LW; lvl++) begin
            if (lvl < lw) begin
                node = {node[3:0], 1'b0} + 5'd1 + {4'd0, tree[node[3:0]]};
            end
        end
        return 4'(node - 5'(ways - 1));
    endfunction

    // Point every node on the accessed way's path away from that way.
    function automatic logic [MAX_TW-1:0] plru_update(input logic [MAX_TW-1:0] tree,
                                                      input logic [MAX_LW-1:0] way,
                                                      input int unsigned       ways);
        logic [MAX_TW-1:0] t;
        logic [4:0]        node;
        logic              b;
        int unsigned       lw;
        t    = tree;
        node = '0;
        lw   = $clog2(ways);
        for (int unsigned lvl = 0; lvl < MAX_LW; lvl++) begin
            if (lvl < lw) begin
                b              = way[2'(lw - 1 - lvl)];
                t[node[3:0]]   = ~b;
                node           = {node[3:0], 1'b0} + 5'd1 + {4'd0, b};
            end
        end
        return t;
    endfunction

endpackage

// File: rtl/l2_cache_ctrl_param_plru.sv
// Combinational tree-PLRU: victim of the current tree and the tree after an access.
module l2_plru_tree
    import l2_cache_ctrl_param_pkg::*;
#(
    parameter int unsigned WAYS = 4
) (
    input  logic [WAYS-2:0]         tree_in,
    input  logic [$clog2(WAYS)-1:0] access_way,
    output logic [WAYS-2:0]         tree_out,
    output logic [$clog2(WAYS)-1:0] victim
);

    localparam int unsigned LW = $clog2(WAYS);
    localparam int unsigned TW = WAYS - 1;

    always_comb begin
        tree_out = TW'(plru_update(MAX_TW'(tree_in), MAX_LW'(access_way), WAYS));
        victim   = LW'(plru_victim(MAX_TW'(tree_in), WAYS));
    end

endmodule

// File: rtl/l2_cache_ctrl_param.sv
// Control FSM for a WAYS-way write-back, write-allocate L2 cache with tree-PLRU,
// invalid-first victim choice, post-hit hold and saturating performance counters.
module l2_cache_ctrl_param
    import l2_cache_ctrl_param_pkg::*;
#(
    parameter int unsigned WAYS     = 4,
    parameter int unsigned HIT_HOLD = 2,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mem_read,
    input  logic                    mem_write,
    output logic                    mem_resp,
    input  logic [WAYS-1:0]         hit,
    input  logic [WAYS-1:0]         valid,
    input  logic [WAYS-1:0]         dirty,
    input  logic [WAYS-2:0]         plru_in,
    output logic [WAYS-2:0]         plru_out,
    output logic                    load_plru,
    output logic [$clog2(WAYS)-1:0] way_sel,
    output logic [WAYS-1:0]         load_write,
    output logic [WAYS-1:0]         load_fill,
    output logic                    pmem_read,
    output logic                    pmem_write,
    input  logic                    pmem_resp,
    output logic                    pmem_addr_sel,
    output logic [CNT_W-1:0]        hit_cnt,
    output logic [CNT_W-1:0]        miss_cnt,
    output logic [CNT_W-1:0]        wb_cnt
);

    localparam int unsigned LW     = $clog2(WAYS);
    localparam int unsigned TW     = plru_width(WAYS);
    localparam int unsigned HOLD_W = 3;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HIT_HOLD > 0) ? HIT_HOLD - 1 : 0);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    l2_state_e         state_q, state_d;
    logic [LW-1:0]     victim_q, victim_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;
    logic [CNT_W-1:0]  wb_cnt_q, wb_cnt_d;

    logic              req_c;
    logic              any_hit_c;
    logic              any_inv_c;
    logic [LW-1:0]     hit_way_c;
    logic [LW-1:0]     inv_way_c;
    logic [LW-1:0]     plru_victim_c;
    logic [LW-1:0]     victim_c;
    logic [TW-1:0]     plru_upd_c;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_W'(1);
    endfunction

    l2_plru_tree #(
        .WAYS (WAYS)
    ) u_plru (
        .tree_in    (plru_in),
        .access_way (hit_way_c),
        .tree_out   (plru_upd_c),
        .victim     (plru_victim_c)
    );

    // Lowest-index hit way and lowest-index invalid way.
    always_comb begin
        hit_way_c = '0;
        inv_way_c = '0;
        any_inv_c = 1'b0;
        for (int i = int'(WAYS) - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hit_way_c = LW'(i);
            end
            if (!valid[i]) begin
                inv_way_c = LW'(i);
                any_inv_c = 1'b1;
            end
        end
    end

    assign req_c     = mem_read ^ mem_write;
    assign any_hit_c = |hit;
    assign victim_c  = any_inv_c ? inv_way_c : plru_victim_c;

    // Next state, counters and decoded strobes.
    always_comb begin
        state_d       = state_q;
        victim_d      = victim_q;
        hold_d        = hold_q;
        hit_cnt_d     = hit_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        wb_cnt_d      = wb_cnt_q;
        mem_resp      = 1'b0;
        load_plru     = 1'b0;
        load_write    = '0;
        load_fill     = '0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        pmem_addr_sel = 1'b0;
        way_sel       = hit_way_c;
        plru_out      = plru_in;

        unique case (state_q)
            IDLE: begin
                if (req_c) begin
                    if (any_hit_c) begin
                        mem_resp  = 1'b1;
                        load_plru = 1'b1;
                        plru_out  = plru_upd_c;
                        if (mem_write) begin
                            load_write[hit_way_c] = 1'b1;
                        end
                        hit_cnt_d = sat_inc(hit_cnt_q);
                        hold_d    = '0;
                        state_d   = (HIT_HOLD > 0) ? HOLD : IDLE;
                    end else begin
                        victim_d   = victim_c;
                        miss_cnt_d = sat_inc(miss_cnt_q);
                        state_d    = (valid[victim_c] && dirty[victim_c]) ? WB : FILL;
                    end
                end
            end
            WB: begin
                pmem_write    = 1'b1;
                pmem_addr_sel = 1'b1;
                way_sel       = victim_q;
                if (pmem_resp) begin
                    wb_cnt_d = sat_inc(wb_cnt_q);
                    state_d  = FILL;
                end
            end
            FILL: begin
                pmem_read = 1'b1;
                way_sel   = victim_q;
                if (pmem_resp) begin
                    load_fill[victim_q] = 1'b1;
                    state_d             = IDLE;
                end
            end
            HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Reset silences every strobe immediately, including the IDLE Mealy ones.
        if (!rst_n) begin
            mem_resp      = 1'b0;
            load_plru     = 1'b0;
            load_write    = '0;
            load_fill     = '0;
            pmem_read     = 1'b0;
            pmem_write    = 1'b0;
            pmem_addr_sel = 1'b0;
            plru_out      = plru_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            victim_q   <= '0;
            hold_q     <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            victim_q   <= victim_d;
            hold_q     <= hold_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            wb_cnt_q   <= wb_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
    assign wb_cnt   = wb_cnt_q;

endmodule

// File: doc/l2_cache_ctrl_param.md
# l2_cache_ctrl_param

- Parametrised control FSM for a WAYS-way set-associative, write-back, write-allocate L2 cache. It sits between the L1 arbiter and physical memory.
- It drives per-way load strobes into the existing tag/data/valid/dirty arrays, steers the datapath way mux and the pmem address mux, and maintains tree-PLRU state.
- It generalises the fixed 4-way controller with:
  - any power-of-two way count;
  - invalid-way-first victim choice;
  - a latched victim;
  - a programmable post-hit hold;
  - saturating performance counters.

## Interface
Parameters:
- WAYS, 4, number of ways; power of two, 2..16
- HIT_HOLD, 2, idle cycles after each hit response (0..7)
- CNT_W, 16, performance counter width

Ports (LW = log2(WAYS)):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- mem_read, mem_write  in  1 each  arbiter request; both high = no request
- mem_resp  out  1  request complete
- hit  in  WAYS  per-way tag match & valid for indexed set
- valid, dirty  in  WAYS each  per-way status for indexed set
- plru_in  in  WAYS-1  PLRU tree of indexed set
- plru_out  out  WAYS-1  updated tree; load_plru  out  1  write strobe
- way_sel  out  LW  datapath read/write-back way mux
- load_write  out  WAYS  one-hot: merge write data, set dirty
- load_fill  out  WAYS  one-hot: load tag+line, valid=1, dirty=0
- pmem_read, pmem_write  out  1 each  memory request
- pmem_resp  in  1  memory done
- pmem_addr_sel  out  1  0 = request address, 1 = victim {tag,index}
- hit_cnt, miss_cnt, wb_cnt  out  CNT_W each  saturating counters

## Operation
- PLRU tree: heap order, node 0 is the root, children of node i are 2i+1 and 2i+2; bit=0 means the victim lies in the left subtree.
  - Victim = leaf reached by following the bits.
  - Access to way w sets every node on w's path to point away from w; all other bits are unchanged.
- Victim choice: lowest-index way with valid=0 if any; otherwise the PLRU victim. It is latched into victim_q on miss detection.
- States and behaviour:
  - IDLE, hit:
    - Hit = |hit and exactly one of read/write.
    - Hit way = lowest-index set bit of hit.
    - Same cycle: mem_resp=1, load_plru=1, way_sel=hit way; write also pulses load_write[hit way]; hit_cnt++.
    - Next state HOLD if HIT_HOLD>0, else IDLE.
  - IDLE, miss:
    - Latch victim_q; miss_cnt++.
    - Next state WB if valid&dirty of victim, else FILL.
  - WB:
    - pmem_write=1, pmem_addr_sel=1, way_sel=victim_q.
    - On pmem_resp: wb_cnt++, next FILL.
  - FILL:
    - pmem_read=1, pmem_addr_sel=0, way_sel=victim_q.
    - On pmem_resp: load_fill[victim_q]=1, next IDLE. The re-lookup then hits; the miss does not respond directly.
  - HOLD: counts HIT_HOLD cycles with all strobes 0, then IDLE.
- Multiple hit bits set (corruption): lowest index wins; no error output.
- Counters stick at 2^CNT_W-1.

## Timing
- Reset (asynchronous, immediate):
  - Registers: state=IDLE, victim_q=0, hold count=0, all counters 0.
  - Outputs: the decoded outputs mem_resp, pmem_read, pmem_write, pmem_addr_sel, load_* are 0 during reset.
  - way_sel and plru_out: way_sel is not forced and follows the lowest-index hit bit; plru_out = plru_in.
- Reset mid-WB/FILL abandons the memory transaction. No array strobe fires.
- Output timing:
  - pmem_read, pmem_write and pmem_addr_sel are Moore outputs decoded from the state register only.
  - mem_resp, load_write and load_plru are Mealy outputs in IDLE.
- Latency:
  - Read hit: 0 cycles to mem_resp, then HIT_HOLD dead cycles.
  - Clean miss: 1 + fill cycles + 1 re-lookup.
  - Dirty miss: adds the WB cycles.
- pmem_resp outside WB/FILL is ignored. A request must be held stable until mem_resp.
- Request deasserted during WB/FILL: the fill completes and the controller returns to IDLE with no mem_resp.

## Structure
- Shared lc3b_types additions:
  - l2_state enum {IDLE, WB, FILL, HOLD};
  - parametrised PLRU width function;
  - functions plru_victim(tree) and plru_update(tree, way).
- Sub-module l2_plru_tree (WAYS param) is purely combinational. Ports: tree_in, access_way, tree_out, victim.
- The controller contains the FSM, victim_q, hold counter and counters.

## Test plan
All scenarios use WAYS=4 and HIT_HOLD=2.
- Read hit way0, plru_in=3'b000 → same-cycle mem_resp=1, plru_out=3'b011, load_plru=1, then 2 cycles with no strobes.
- Read miss, valid=4'b1111, dirty=0, plru_in=3'b011 → victim 2; FILL with pmem_read=1 until pmem_resp; load_fill=4'b0100; re-lookup hit responds.
- Write miss, victim 3 dirty (plru_in=3'b101) → WB with pmem_write=1 and pmem_addr_sel=1 until pmem_resp; then FILL; hit; load_write=4'b1000; wb_cnt=1.
- valid=4'b1011 miss with PLRU pointing at way0 → victim way 2 (invalid first).
- Assert rst_n=0 mid-FILL → pmem_read drops in the same cycle, state=IDLE, counters=0, no load_fill.
- CNT_W=4, drive 20 hits → hit_cnt saturates at 15; mem_read=mem_write=1 → no response and no state change.
